// File: rtl/hazard_ctrl_unit.sv
// ID/EX hazard controller: load-use bubbles, multi-cycle redirect flushes and a
// data-memory freeze with a sticky timeout watchdog. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_ex_memread,
   input  logic [4:0] id_ex_rd,
   input  logic [4:0] if_id_rs1,
   input  logic [4:0] if_id_rs2,
   input  logic       uses_rs1,
   input  logic       uses_rs2,
   input  logic       ex_redirect,
   input  logic       mem_busy,
   output logic       pc_write,
   output logic       if_id_write,
   output logic       ex_control,
   output logic       if_id_flush,
   output logic       pipe_freeze,
   output logic       mem_timeout,
   output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] perf_lu_stalls,
   output logic [31:0] perf_flush_cycles,
   output logic [31:0] perf_freeze_cycles
`endif
);

   localparam int FCW_RAW = $clog2(FLUSH_CYCLES + 1);
   localparam int FCW     = (FCW_RAW < 1) ? 1 : FCW_RAW;
   localparam logic [FCW-1:0] FLUSH_LAST  = FCW'(FLUSH_CYCLES - 1);
   localparam logic [15:0]    TIMEOUT_LIM = 16'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_ILLEGAL  = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      OUT_NORMAL,
      OUT_FREEZE,
      OUT_FLUSH,
      OUT_BUBBLE,
      OUT_RESET
   } out_e;

   state_e         state_q, state_d;
   logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
   logic [15:0]    wait_cnt_q, wait_cnt_d;
   logic           mem_timeout_q, mem_timeout_d;

   out_e out_sel;
   logic run_eval;
   logic lu;
   logic lu_bubble;

   assign lu = id_ex_memread && (id_ex_rd != 5'd0) &&
               ((uses_rs1 && (if_id_rs1 == id_ex_rd)) ||
                (uses_rs2 && (if_id_rs2 == id_ex_rd)));

   always_comb begin
      state_d       = state_q;
      flush_cnt_d   = flush_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      out_sel       = OUT_NORMAL;
      run_eval      = 1'b0;
      lu_bubble     = 1'b0;

      case (state_q)
         ST_RUN: run_eval = 1'b1;

         ST_FLUSH: begin
            if (mem_busy) begin
               out_sel     = OUT_FREEZE;
               state_d     = ST_MEM_WAIT;
               flush_cnt_d = '0;
               wait_cnt_d  = 16'd1;
            end else if (ex_redirect) begin
               out_sel     = OUT_FLUSH;
               flush_cnt_d = FCW'(1);
            end else begin
               out_sel = OUT_FLUSH;
               if (flush_cnt_q == FLUSH_LAST) begin
                  state_d     = ST_RUN;
                  flush_cnt_d = '0;
               end else begin
                  flush_cnt_d = flush_cnt_q + FCW'(1);
               end
            end
         end

         ST_MEM_WAIT: begin
            if (mem_busy) begin
               out_sel = OUT_FREEZE;
               if (wait_cnt_q != 16'hFFFF) begin
                  wait_cnt_d = wait_cnt_q + 16'd1;
               end
               // wait_cnt_q counts busy cycles already seen in this freeze
               if (wait_cnt_q >= TIMEOUT_LIM) begin
                  mem_timeout_d = 1'b1;
               end
            end else begin
               run_eval = 1'b1;
            end
         end

         default: begin
            out_sel     = OUT_BUBBLE;
            state_d     = ST_RUN;
            flush_cnt_d = '0;
            wait_cnt_d  = '0;
         end
      endcase

      // Release cycle of MEM_WAIT shares the RUN decision path
      if (run_eval) begin
         if (mem_busy) begin
            out_sel     = OUT_FREEZE;
            state_d     = ST_MEM_WAIT;
            flush_cnt_d = '0;
            wait_cnt_d  = 16'd1;
         end else if (ex_redirect) begin
            out_sel    = OUT_FLUSH;
            wait_cnt_d = '0;
            if (FLUSH_CYCLES > 1) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = FCW'(1);
            end else begin
               state_d     = ST_RUN;
               flush_cnt_d = '0;
            end
         end else if (lu) begin
            out_sel     = OUT_BUBBLE;
            lu_bubble   = 1'b1;
            state_d     = ST_RUN;
            flush_cnt_d = '0;
            wait_cnt_d  = '0;
         end else begin
            state_d     = ST_RUN;
            flush_cnt_d = '0;
            wait_cnt_d  = '0;
         end
      end

      if (reset) begin
         out_sel   = OUT_RESET;
         lu_bubble = 1'b0;
      end
   end

   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      ex_control  = 1'b1;
      if_id_flush = 1'b0;
      pipe_freeze = 1'b0;
      case (out_sel)
         OUT_FREEZE: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
         end
         OUT_FLUSH: begin
            ex_control  = 1'b0;
            if_id_flush = 1'b1;
         end
         OUT_BUBBLE: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_control  = 1'b0;
         end
         OUT_RESET: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_control  = 1'b0;
            if_id_flush = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_RUN;
         flush_cnt_q   <= '0;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         flush_cnt_q   <= flush_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout = mem_timeout_q;
   assign state_o     = state_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_lu_q, perf_flush_q, perf_freeze_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_lu_q     <= '0;
         perf_flush_q  <= '0;
         perf_freeze_q <= '0;
      end else begin
         if (lu_bubble)   perf_lu_q     <= perf_lu_q + 32'd1;
         if (if_id_flush) perf_flush_q  <= perf_flush_q + 32'd1;
         if (pipe_freeze) perf_freeze_q <= perf_freeze_q + 32'd1;
      end
   end

   assign perf_lu_stalls     = perf_lu_q;
   assign perf_flush_cycles  = perf_flush_q;
   assign perf_freeze_cycles = perf_freeze_q;
`else
   logic unused_lu_bubble;
   assign unused_lu_bubble = lu_bubble;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios then random stimulus,
// all outputs compared every cycle against a behavioural model of the hazard rules.
module tb_hazard_ctrl_unit;

   localparam int FC = 3;
   localparam int MT = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_ex_memread;
   logic [4:0] id_ex_rd, if_id_rs1, if_id_rs2;
   logic       uses_rs1, uses_rs2, ex_redirect, mem_busy;
   logic       pc_write, if_id_write, ex_control, if_id_flush, pipe_freeze, mem_timeout;
   logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_lu_stalls, perf_flush_cycles, perf_freeze_cycles;
`endif

   hazard_ctrl_unit #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
      .clk(clk), .reset(reset),
      .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
      .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
      .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
      .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .pc_write(pc_write), .if_id_write(if_id_write), .ex_control(ex_control),
      .if_id_flush(if_id_flush), .pipe_freeze(pipe_freeze),
      .mem_timeout(mem_timeout), .state_o(state_o)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_lu_stalls(perf_lu_stalls), .perf_flush_cycles(perf_flush_cycles),
      .perf_freeze_cycles(perf_freeze_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model: flush cycles still owed, consecutive busy count, frozen flag
   int          m_flush_left = 0;
   int          m_busy_run   = 0;
   bit          m_frozen     = 0;
   bit          m_timeout    = 0;
   int unsigned m_perf_lu = 0, m_perf_fl = 0, m_perf_frz = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL cyc %0d %s: got %0h expected %0h", cyc, tag, got, exp);
      end
   endtask

   task automatic step(input bit rst, input bit mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input bit red, input bit busy);
      bit e_pc, e_ifw, e_exc, e_fl, e_frz, lu_hit, bubble;
      int e_state;
      @(negedge clk);
      reset = rst; id_ex_memread = mr; id_ex_rd = rd; if_id_rs1 = rs1; if_id_rs2 = rs2;
      uses_rs1 = u1; uses_rs2 = u2; ex_redirect = red; mem_busy = busy;
      #1;
      lu_hit = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      bubble = 0;
      e_state = m_frozen ? 2 : ((m_flush_left > 0) ? 1 : 0);
      if (rst)                            {e_pc, e_ifw, e_exc, e_fl, e_frz} = 5'b00010;
      else if (busy)                      {e_pc, e_ifw, e_exc, e_fl, e_frz} = 5'b00101;
      else if (red || m_flush_left > 0)   {e_pc, e_ifw, e_exc, e_fl, e_frz} = 5'b11010;
      else if (lu_hit) begin
         {e_pc, e_ifw, e_exc, e_fl, e_frz} = 5'b00000;
         bubble = 1;
      end else                            {e_pc, e_ifw, e_exc, e_fl, e_frz} = 5'b11100;

      $display("cyc %0d rst=%0b busy=%0b red=%0b lu=%0b -> pc=%0b ifw=%0b exc=%0b fl=%0b frz=%0b st=%0d to=%0b",
               cyc, rst, busy, red, lu_hit, pc_write, if_id_write, ex_control,
               if_id_flush, pipe_freeze, state_o, mem_timeout);
      chk("pc_write",    32'(pc_write),    32'(e_pc));
      chk("if_id_write", 32'(if_id_write), 32'(e_ifw));
      chk("ex_control",  32'(ex_control),  32'(e_exc));
      chk("if_id_flush", 32'(if_id_flush), 32'(e_fl));
      chk("pipe_freeze", 32'(pipe_freeze), 32'(e_frz));
      chk("state_o",     32'(state_o),     32'(e_state));
      chk("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
`ifdef HAZARD_PERF_CNT_EN
      chk("perf_lu",     perf_lu_stalls,     m_perf_lu);
      chk("perf_flush",  perf_flush_cycles,  m_perf_fl);
      chk("perf_freeze", perf_freeze_cycles, m_perf_frz);
`endif

      if (rst) begin
         m_flush_left = 0; m_busy_run = 0; m_frozen = 0; m_timeout = 0;
         m_perf_lu = 0; m_perf_fl = 0; m_perf_frz = 0;
      end else begin
         if (bubble) m_perf_lu++;
         if (e_fl)   m_perf_fl++;
         if (e_frz)  m_perf_frz++;
         if (busy) begin
            m_busy_run++;
            if (m_busy_run > MT) m_timeout = 1;
            m_flush_left = 0;
            m_frozen = 1;
         end else begin
            m_busy_run = 0;
            m_frozen = 0;
            if (red) m_flush_left = FC - 1;
            else if (m_flush_left > 0) m_flush_left--;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1; id_ex_memread = 0; id_ex_rd = 0; if_id_rs1 = 0; if_id_rs2 = 0;
      uses_rs1 = 0; uses_rs2 = 0; ex_redirect = 0; mem_busy = 0;

      for (int k = 0; k < 3; k++) step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
      chk("rst_flush", 32'(if_id_flush), 32'd1);
      idle(1);

      // load-use on rs1, then release
      step(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
      chk("lu_pc_stall", 32'(pc_write), 32'd0);
      step(0, 0, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0);
      chk("lu_release", 32'(ex_control), 32'd1);

      // x0 destination and unused rs2 never stall
      step(0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
      chk("x0_no_stall", 32'(pc_write), 32'd1);
      step(0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0);
      chk("unused_rs2", 32'(pc_write), 32'd1);

      // redirect: three flush cycles
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      idle(3);

      // redirect with simultaneous load-use
      step(0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0);
      chk("red_lu_pc", 32'(pc_write), 32'd1);
      idle(3);

      // four busy cycles, MT=3 -> timeout, sticky
      for (int k = 0; k < 4; k++) step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
      idle(1);
      chk("timeout_set", 32'(mem_timeout), 32'd1);
      idle(2);

      // reset in MEM_WAIT (entered from FLUSH)
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
      step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
      idle(1);
      chk("rst_mw_state", 32'(state_o), 32'd0);

      // reset in FLUSH
      step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
      step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
      idle(1);
      chk("rst_fl_state", 32'(state_o), 32'd0);

      // random phase with small register indices to provoke hazards
      for (int k = 0; k < 1500; k++) begin
         step(($urandom_range(0, 59) == 0),
              1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 6) == 0),
              ($urandom_range(0, 3) == 0) || (mem_busy && $urandom_range(0, 2) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
